platform_motion: RTL and testbench

Per-frame position generator for the horizontal platform that the VGA logic stage draws. It produces the 10-bit platform start and end columns that the renderer compares against its pixel counter. The platform sweeps back and forth across the active area, dwells at each edge, and updates only at frame boundaries so that no frame shows a torn platform. It runs on the 25 MHz pixel clock, the same clock as the renderer.

---
 rtl/platform_motion.sv | 159 +++++++++++++++
 tb/tb_platform_motion.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/platform_motion.sv
// -----------------------------------------------------------------------------
// platform_motion
//
// Per-frame position generator for the horizontal platform drawn by the VGA
// renderer. The platform sweeps right, dwells at the right edge, sweeps left,
// dwells at the left edge, and repeats. Position changes only on a frame
// event, so the renderer never sees a torn platform within a frame.
//
// Parameters
//   H_ACTIVE      active pixels per line (right screen limit)
//   WIDTH         platform width in pixels, 1..H_ACTIVE
//   SPEED         pixels moved per frame, >= 1
//   DWELL_FRAMES  extra frames held at an edge before reversing (0 allowed)
//   INIT_START    start column after reset, <= H_ACTIVE - WIDTH
//
// Ports
//   clk              in   pixel clock, rising edge
//   reset            in   asynchronous active-low reset
//   enable           in   1 = frame events act, 0 = outputs frozen
//   frame_tick       in   frame-boundary strobe; its rising edge is the event
//   plataform_start  out  leftmost platform column
//   plataform_end    out  rightmost platform column (start + WIDTH - 1)
//   direction        out  1 while moving/holding on the right sweep
//   at_edge          out  1 while in a hold state
// -----------------------------------------------------------------------------
module platform_motion #(
    parameter int H_ACTIVE     = 640,
    parameter int WIDTH        = 128,
    parameter int SPEED        = 2,
    parameter int DWELL_FRAMES = 30,
    parameter int INIT_START   = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    output logic [9:0] plataform_start,
    output logic [9:0] plataform_end,
    output logic       direction,
    output logic       at_edge
);

    typedef enum logic [1:0] {
        MOVE_R = 2'd0,
        HOLD_R = 2'd1,
        MOVE_L = 2'd2,
        HOLD_L = 2'd3
    } state_e;

    localparam int DW = (DWELL_FRAMES > 0) ? $clog2(DWELL_FRAMES + 1) : 1;

    // 11-bit versions are used for comparisons so start + SPEED cannot wrap
    // before it is clamped against the right limit.
    localparam logic [10:0]   MAX_START_W = 11'(H_ACTIVE - WIDTH);
    localparam logic [10:0]   STEP_W      = 11'(SPEED);
    localparam logic [9:0]    MAX_START   = 10'(H_ACTIVE - WIDTH);
    localparam logic [9:0]    STEP        = 10'(SPEED);
    localparam logic [9:0]    END_OFFSET  = 10'(WIDTH - 1);
    localparam logic [9:0]    INIT_POS    = 10'(INIT_START);
    localparam logic [9:0]    INIT_END    = 10'(INIT_START + WIDTH - 1);
    localparam logic [DW-1:0] DWELL_LOAD  = DW'(DWELL_FRAMES);

    // First column after leaving each edge, clamped to the legal range.
    localparam logic [9:0] LEFT_REENTRY  = (SPEED >= H_ACTIVE - WIDTH) ? 10'd0
                                         : 10'(H_ACTIVE - WIDTH - SPEED);
    localparam logic [9:0] RIGHT_REENTRY = (SPEED < H_ACTIVE - WIDTH) ? 10'(SPEED)
                                         : MAX_START;

    state_e          state_q, state_d;
    logic [9:0]      start_q, start_d;
    logic [9:0]      end_q;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            tick_q;
    logic            direction_q;
    logic            at_edge_q;
    logic            frame_event;
    logic [10:0]     start_ext;

    // tick_q resets high so a tick already asserted at reset release is not
    // mistaken for a new frame.
    assign frame_event = frame_tick & ~tick_q & enable;
    assign start_ext   = {1'b0, start_q};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        start_d = start_q;
        dwell_d = dwell_q;
        if (frame_event) begin
            case (state_q)
                MOVE_R: begin
                    if (start_ext + STEP_W >= MAX_START_W) begin
                        start_d = MAX_START;
                        dwell_d = DWELL_LOAD;
                        state_d = HOLD_R;
                    end else begin
                        start_d = start_q + STEP;
                    end
                end
                HOLD_R: begin
                    if (dwell_q == '0) begin
                        start_d = LEFT_REENTRY;
                        state_d = MOVE_L;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
                MOVE_L: begin
                    if (start_ext <= STEP_W) begin
                        start_d = 10'd0;
                        dwell_d = DWELL_LOAD;
                        state_d = HOLD_L;
                    end else begin
                        start_d = start_q - STEP;
                    end
                end
                HOLD_L: begin
                    if (dwell_q == '0) begin
                        start_d = RIGHT_REENTRY;
                        state_d = MOVE_R;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs are registered from the next-state values so they change on the
    // same edge as the position and stay stable for the rest of the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MOVE_R;
            start_q     <= INIT_POS;
            end_q       <= INIT_END;
            dwell_q     <= '0;
            tick_q      <= 1'b1;
            direction_q <= 1'b1;
            at_edge_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            tick_q      <= frame_tick;
            state_q     <= state_d;
            start_q     <= start_d;
            end_q       <= start_d + END_OFFSET;
            dwell_q     <= dwell_d;
            direction_q <= (state_d == MOVE_R) || (state_d == HOLD_R);
            at_edge_q   <= (state_d == HOLD_R) || (state_d == HOLD_L);
        end
    end

    assign plataform_start = start_q;
    assign plataform_end   = end_q;
    assign direction       = direction_q;
    assign at_edge         = at_edge_q;

endmodule

// File: tb/tb_platform_motion.sv
// -----------------------------------------------------------------------------
// tb_platform_motion
//
// Directed bench for platform_motion. Instance a uses the default parameters;
// instance b is a small screen (H_ACTIVE=19, WIDTH=8, SPEED=3, DWELL=0,
// INIT_START=10) used to reach the left edge in a handful of frames.
// -----------------------------------------------------------------------------
module tb_platform_motion;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       tick_a;
    logic       tick_b;
    logic       enable_b;
    logic [9:0] a_start, a_end, b_start, b_end;
    logic       a_dir, a_edge, b_dir, b_edge;

    int checks   = 0;
    int failures = 0;

    platform_motion dut_a (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .frame_tick      (tick_a),
        .plataform_start (a_start),
        .plataform_end   (a_end),
        .direction       (a_dir),
        .at_edge         (a_edge)
    );

    platform_motion #(
        .H_ACTIVE     (19),
        .WIDTH        (8),
        .SPEED        (3),
        .DWELL_FRAMES (0),
        .INIT_START   (10)
    ) dut_b (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable_b),
        .frame_tick      (tick_b),
        .plataform_start (b_start),
        .plataform_end   (b_end),
        .direction       (b_dir),
        .at_edge         (b_edge)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One single-cycle tick; outputs are sampled at the negedge after it.
    task automatic pulse_a();
        @(negedge clk) tick_a = 1'b1;
        @(negedge clk) tick_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_b();
        @(negedge clk) tick_b = 1'b1;
        @(negedge clk) tick_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_a(input string name, input logic [9:0] s, input logic [9:0] e,
                            input logic d, input logic g);
        checks++;
        if ({a_start, a_end, a_dir, a_edge} !== {s, e, d, g}) begin
            failures++;
            $display("FAIL %s: got start=%0d end=%0d dir=%0b edge=%0b, want %0d/%0d/%0b/%0b",
                     name, a_start, a_end, a_dir, a_edge, s, e, d, g);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        tick_a = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        expect_a("reset_tick_high", 10'd256, 10'd383, 1'b1, 1'b0);
        tick_a = 1'b0;
        repeat (2) @(negedge clk);
        expect_a("tick_fall_no_move", 10'd256, 10'd383, 1'b1, 1'b0);
    endtask

    task automatic test_step();
        pulse_a();
        expect_a("step1", 10'd258, 10'd385, 1'b1, 1'b0);
        pulse_a();
        expect_a("step2", 10'd260, 10'd387, 1'b1, 1'b0);
        pulse_a();
        expect_a("step3", 10'd262, 10'd389, 1'b1, 1'b0);
    endtask

    task automatic test_long_tick();
        @(negedge clk) tick_a = 1'b1;
        repeat (50) @(negedge clk);
        expect_a("long_tick_held", 10'd264, 10'd391, 1'b1, 1'b0);
        tick_a = 1'b0;
        repeat (2) @(negedge clk);
        expect_a("long_tick_released", 10'd264, 10'd391, 1'b1, 1'b0);
    endtask

    task automatic test_right_edge();
        repeat (123) pulse_a();
        expect_a("sweep_to_510", 10'd510, 10'd637, 1'b1, 1'b0);
        pulse_a();
        expect_a("enter_hold_r", 10'd512, 10'd639, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            pulse_a();
            expect_a($sformatf("dwell_%0d", i), 10'd512, 10'd639, 1'b1, 1'b1);
        end
        pulse_a();
        expect_a("leave_hold_r", 10'd510, 10'd637, 1'b0, 1'b0);
    endtask

    task automatic test_enable();
        enable = 1'b0;
        repeat (5) pulse_a();
        expect_a("disabled_ticks", 10'd510, 10'd637, 1'b0, 1'b0);
        @(negedge clk) tick_a = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        expect_a("enable_during_high", 10'd510, 10'd637, 1'b0, 1'b0);
        tick_a = 1'b0;
        @(negedge clk);
        pulse_a();
        expect_a("step_after_enable", 10'd508, 10'd635, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_dwell();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        expect_a("reset_pulse", 10'd256, 10'd383, 1'b1, 1'b0);
        repeat (127) pulse_a();
        pulse_a();
        expect_a("hold_r_again", 10'd512, 10'd639, 1'b1, 1'b1);
        repeat (18) pulse_a();
        expect_a("hold_r_dwell12", 10'd512, 10'd639, 1'b1, 1'b1);
        @(posedge clk);
        #5 reset = 1'b0;
        #1 expect_a("async_reset", 10'd256, 10'd383, 1'b1, 1'b0);
        @(negedge clk) reset = 1'b1;
        pulse_a();
        expect_a("after_reset_step", 10'd258, 10'd385, 1'b1, 1'b0);
    endtask

    task automatic test_left_edge();
        pulse_b();
        checks++;
        if ({b_start, b_end, b_dir, b_edge} !== {10'd11, 10'd18, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL b_hold_r: got %0d/%0d/%0b/%0b want 11/18/1/1", b_start, b_end, b_dir, b_edge);
        end
        pulse_b();
        checks++;
        if ({b_start, b_dir, b_edge} !== {10'd8, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b_reverse: got %0d/%0b/%0b want 8/0/0", b_start, b_dir, b_edge);
        end
        pulse_b();
        pulse_b();
        checks++;
        if ({b_start, b_end, b_dir, b_edge} !== {10'd2, 10'd9, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b_start2: got %0d/%0d/%0b/%0b want 2/9/0/0", b_start, b_end, b_dir, b_edge);
        end
        pulse_b();
        checks++;
        if ({b_start, b_end, b_dir, b_edge} !== {10'd0, 10'd7, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL b_hold_l: got %0d/%0d/%0b/%0b want 0/7/0/1", b_start, b_end, b_dir, b_edge);
        end
        pulse_b();
        checks++;
        if ({b_start, b_end, b_dir, b_edge} !== {10'd3, 10'd10, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b_move_r: got %0d/%0d/%0b/%0b want 3/10/1/0", b_start, b_end, b_dir, b_edge);
        end
    endtask

    initial begin
        tick_b   = 1'b0;
        enable_b = 1'b1;
        test_reset();
        test_step();
        test_long_tick();
        test_right_edge();
        test_enable();
        test_reset_mid_dwell();
        test_left_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
